// File: rtl/dm_mem_mh_pkg.sv
// Shared constants, FSM state type and jal encoder for the multi-hart debug memory.
package dm_mem_pkg;

  localparam int HALTED_ADDR    = 32'h100;
  localparam int GOING_ADDR     = 32'h108;
  localparam int RESUMING_ADDR  = 32'h110;
  localparam int EXCEPTION_ADDR = 32'h118;
  localparam int WHERETO_ADDR   = 32'h300;
  localparam int DATA_ADDR      = 32'h380;
  localparam int FLAGS_ADDR     = 32'h400;
  localparam int ABSCMD_WORDS   = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD_GO   = 2'd1,
    CMD_EXEC = 2'd2,
    RESUME   = 2'd3
  } dm_state_e;

  // RISC-V J-type: imm[20|10:1|11|19:12] rd opcode(jal)
  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:1] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

endpackage

// File: rtl/dm_mem_mh_if.sv
// Hart-side bus into the debug memory window: request in, fixed-latency response out.
interface dm_mem_mh_if #(
  parameter int DbgAddressBits = 12,
  parameter int BusWidth       = 64
);
  logic                      req_i;
  logic                      we_i;
  logic [DbgAddressBits-1:0] addr_i;
  logic [BusWidth-1:0]       wdata_i;
  logic [BusWidth/8-1:0]     be_i;
  logic                      rvalid_o;
  logic [BusWidth-1:0]       rdata_o;

  modport master (output req_i, we_i, addr_i, wdata_i, be_i, input rvalid_o, rdata_o);
  modport slave  (input req_i, we_i, addr_i, wdata_i, be_i, output rvalid_o, rdata_o);
endinterface

// File: rtl/dm_mem_mh_hart_status.sv
// Per-hart halted/resuming flags; a bus write to a hart beats a same-cycle ack clear.
module dm_mem_hart_status #(
  parameter int NrHarts    = 4,
  parameter int HartSelLen = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_halt_i,
  input  logic                  set_resume_i,
  input  logic [HartSelLen-1:0] wr_id_i,
  input  logic                  clr_ack_i,
  input  logic [HartSelLen-1:0] clr_id_i,
  output logic [NrHarts-1:0]    halted_o,
  output logic [NrHarts-1:0]    resuming_o
);

  logic [NrHarts-1:0] r_halted, r_resuming;
  logic [NrHarts-1:0] w_hit_wr, w_hit_clr;

  always_comb begin
    w_hit_wr  = '0;
    w_hit_clr = '0;
    for (int h = 0; h < NrHarts; h++) begin
      w_hit_wr[h]  = (int'(wr_id_i) == h);
      w_hit_clr[h] = (int'(clr_id_i) == h);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_halted   <= '0;
      r_resuming <= '0;
    end else begin
      for (int h = 0; h < NrHarts; h++) begin
        if (set_halt_i && w_hit_wr[h]) begin
          r_halted[h]   <= 1'b1;
          r_resuming[h] <= 1'b0;
        end else if (set_resume_i && w_hit_wr[h]) begin
          r_halted[h]   <= 1'b0;
          r_resuming[h] <= 1'b1;
        end else if (clr_ack_i && w_hit_clr[h]) begin
          r_resuming[h] <= 1'b0;
        end
      end
    end
  end

  assign halted_o   = r_halted;
  assign resuming_o = r_resuming;

endmodule

// File: rtl/dm_mem_mh.sv
// Multi-hart debug ROM/RAM window: write decode, abstract-command/resume FSM and a
// one-cycle registered read mux, all evaluated per 32-bit lane of the bus.
module dm_mem_mh
  import dm_mem_pkg::*;
#(
  parameter int NrHarts        = 4,
  parameter int BusWidth       = 64,
  parameter int DataCount      = 2,
  parameter int ProgBufSize    = 8,
  parameter int DbgAddressBits = 12,
  parameter int HartSelLen     = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  dm_mem_mh_if.slave                       bus,
  input  logic [HartSelLen-1:0]            hartsel_i,
  input  logic                             cmd_valid_i,
  input  logic                             resumereq_i,
  input  logic                             clear_resumeack_i,
  input  logic [ProgBufSize-1:0][31:0]     progbuf_i,
  input  logic [ABSCMD_WORDS-1:0][31:0]    abs_cmd_i,
  input  logic [DataCount-1:0][31:0]       data_i,
  output logic [DataCount-1:0][31:0]       data_o,
  output logic                             data_valid_o,
  output logic [NrHarts-1:0]               halted_o,
  output logic [NrHarts-1:0]               resuming_o,
  output logic                             cmdbusy_o,
  output logic                             cmd_exc_o
);

  localparam int NW           = BusWidth / 32;
  localparam int NB           = BusWidth / 8;
  localparam int PROGBUF_ADDR = DATA_ADDR - 4 * ProgBufSize;
  localparam int ABSCMD_ADDR  = PROGBUF_ADDR - 4 * ABSCMD_WORDS;
  localparam logic [31:0] ABS_OFF = 32'(ABSCMD_ADDR - WHERETO_ADDR);
  localparam logic [31:0] PB_OFF  = 32'(PROGBUF_ADDR - WHERETO_ADDR);
  localparam logic [31:0] JAL_ABS = jal(5'd0, ABS_OFF[20:1]);
  localparam logic [31:0] JAL_PB  = jal(5'd0, PB_OFF[20:1]);
  localparam logic [DbgAddressBits-1:0] ALIGN_MASK = DbgAddressBits'(NB - 1);

  logic [DbgAddressBits-1:0] w_aaddr;
  int                        w_base;
  logic                      w_wr, w_wr_halted, w_wr_going, w_wr_resuming, w_wr_exc, w_wr_data;
  logic [HartSelLen-1:0]     w_wid;
  logic                      w_sel_halted, w_exc;
  logic [NW-1:0][31:0]       w_rd;
  dm_state_e                 r_state, w_state_nxt;
  logic                      r_rvalid, r_dvalid, r_cmd_exc;
  logic [BusWidth-1:0]       r_rdata;
  logic [DataCount-1:0][31:0] r_data;

  // Every access is treated as bus-aligned; sub-word offsets select nothing.
  assign w_aaddr       = bus.addr_i & ~ALIGN_MASK;
  assign w_base        = int'(w_aaddr);
  assign w_wr          = bus.req_i & bus.we_i;
  assign w_wr_halted   = w_wr && (w_base == HALTED_ADDR);
  assign w_wr_going    = w_wr && (w_base == GOING_ADDR);
  assign w_wr_resuming = w_wr && (w_base == RESUMING_ADDR);
  assign w_wr_exc      = w_wr && (w_base == EXCEPTION_ADDR);
  assign w_wid         = bus.wdata_i[HartSelLen-1:0];

  dm_mem_hart_status #(
    .NrHarts    (NrHarts),
    .HartSelLen (HartSelLen)
  ) u_status (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .set_halt_i   (w_wr_halted),
    .set_resume_i (w_wr_resuming),
    .wr_id_i      (w_wid),
    .clr_ack_i    (clear_resumeack_i),
    .clr_id_i     (hartsel_i),
    .halted_o     (halted_o),
    .resuming_o   (resuming_o)
  );

  always_comb begin
    w_sel_halted = 1'b0;
    for (int h = 0; h < NrHarts; h++)
      if (int'(hartsel_i) == h) w_sel_halted = halted_o[h];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i && w_sel_halted)      w_state_nxt = CMD_GO;
        else if (resumereq_i && w_sel_halted) w_state_nxt = RESUME;
      end
      CMD_GO:   if (w_wr_going) w_state_nxt = CMD_EXEC;
      CMD_EXEC: begin
        if (w_wr_halted) w_state_nxt = IDLE;
        else if (w_wr_exc) begin
          w_state_nxt = IDLE;
          w_exc       = 1'b1;
        end
      end
      RESUME:   if (w_wr_resuming) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wr_data = 1'b0;
    for (int k = 0; k < NW; k++)
      for (int d = 0; d < DataCount; d++)
        if (w_wr && (w_base + 4 * k == DATA_ADDR + 4 * d)) w_wr_data = 1'b1;
  end

  // Read mux per 32-bit lane; anything not matched reads as zero.
  always_comb begin
    int wa;
    wa   = 0;
    w_rd = '0;
    for (int k = 0; k < NW; k++) begin
      wa = w_base + 4 * k;
      if (wa == WHERETO_ADDR)
        w_rd[k] = (r_state == CMD_GO || r_state == CMD_EXEC) ? JAL_ABS : JAL_PB;
      for (int a = 0; a < ABSCMD_WORDS; a++)
        if (wa == ABSCMD_ADDR + 4 * a) w_rd[k] = abs_cmd_i[a];
      for (int p = 0; p < ProgBufSize; p++)
        if (wa == PROGBUF_ADDR + 4 * p) w_rd[k] = progbuf_i[p];
      for (int d = 0; d < DataCount; d++)
        if (wa == DATA_ADDR + 4 * d) w_rd[k] = data_i[d];
      for (int b = 0; b < 4; b++)
        if (wa + b == FLAGS_ADDR + int'(hartsel_i))
          w_rd[k][8*b +: 8] = {6'b0, r_state == RESUME, r_state == CMD_GO};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_dvalid  <= 1'b0;
      r_cmd_exc <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rvalid  <= bus.req_i;
      r_rdata   <= (bus.req_i && !bus.we_i) ? w_rd : '0;
      r_dvalid  <= w_wr_data;
      r_cmd_exc <= w_exc;
      for (int k = 0; k < NW; k++)
        for (int d = 0; d < DataCount; d++)
          if (w_wr && (w_base + 4 * k == DATA_ADDR + 4 * d))
            for (int b = 0; b < 4; b++)
              if (bus.be_i[4*k + b]) r_data[d][8*b +: 8] <= bus.wdata_i[32*k + 8*b +: 8];
    end
  end

  assign bus.rvalid_o = r_rvalid;
  assign bus.rdata_o  = r_rdata;
  assign data_o       = r_data;
  assign data_valid_o = r_dvalid;
  assign cmd_exc_o    = r_cmd_exc;
  assign cmdbusy_o    = (r_state == CMD_GO) || (r_state == CMD_EXEC);

endmodule

// File: tb/tb_dm_mem_mh.sv
// Directed bench for dm_mem_mh at default parameters (4 harts, 64-bit bus).
module tb_dm_mem_mh;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       hartsel;
  logic             cmd_valid, resumereq, clear_ack;
  logic [7:0][31:0] progbuf;
  logic [9:0][31:0] abs_cmd;
  logic [1:0][31:0] data_in, data_out;
  logic             data_valid;
  logic [3:0]       halted, resuming;
  logic             cmdbusy, cmd_exc;
  int               checks = 0;
  int               failures = 0;

  localparam logic [31:0] JAL_ABS = 32'h0380006F;
  localparam logic [31:0] JAL_PB  = 32'h0600006F;

  always #5 clk = ~clk;

  dm_mem_mh_if #(.DbgAddressBits(12), .BusWidth(64)) bus ();

  dm_mem_mh dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .bus               (bus),
    .hartsel_i         (hartsel),
    .cmd_valid_i       (cmd_valid),
    .resumereq_i       (resumereq),
    .clear_resumeack_i (clear_ack),
    .progbuf_i         (progbuf),
    .abs_cmd_i         (abs_cmd),
    .data_i            (data_in),
    .data_o            (data_out),
    .data_valid_o      (data_valid),
    .halted_o          (halted),
    .resuming_o        (resuming),
    .cmdbusy_o         (cmdbusy),
    .cmd_exc_o         (cmd_exc)
  );

  task automatic bus_wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [63:0] d);
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.be_i = 8'hFF;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic pulse_cmd(input logic c, input logic r);
    @(negedge clk);
    cmd_valid = c; resumereq = r;
    @(posedge clk); #1;
    cmd_valid = 1'b0; resumereq = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    hartsel = '0; cmd_valid = 1'b0; resumereq = 1'b0; clear_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    do_reset();
    checks++;
    if ({bus.rvalid_o, bus.rdata_o, halted, resuming, data_out, data_valid, cmdbusy, cmd_exc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rv=%b rd=%h h=%b r=%b d=%h dv=%b busy=%b exc=%b, want all 0",
               bus.rvalid_o, bus.rdata_o, halted, resuming, data_out, data_valid, cmdbusy, cmd_exc);
    end
    bus_rd(12'h300, rd);
    checks++;
    if (rd !== {32'h0, JAL_PB}) begin failures++; $display("FAIL reset_whereto: got %h want %h", rd, {32'h0, JAL_PB}); end
  endtask

  task automatic test_halt_resume();
    logic [63:0] rd;
    do_reset();
    bus_wr(12'h100, 64'd2, 8'hFF);
    checks++;
    if ({halted, resuming} !== {4'b0100, 4'b0000}) begin
      failures++; $display("FAIL halted_write: got h=%b r=%b want h=0100 r=0000", halted, resuming);
    end
    checks++;
    if ({bus.rvalid_o, bus.rdata_o} !== {1'b1, 64'h0}) begin
      failures++; $display("FAIL write_response: got rv=%b rd=%h want rv=1 rd=0", bus.rvalid_o, bus.rdata_o);
    end
    bus_wr(12'h110, 64'd2, 8'hFF);
    checks++;
    if ({halted, resuming} !== {4'b0000, 4'b0100}) begin
      failures++; $display("FAIL resuming_write: got h=%b r=%b want h=0000 r=0100", halted, resuming);
    end
    hartsel = 2'd2;
    @(negedge clk); clear_ack = 1'b1;
    @(posedge clk); #1; clear_ack = 1'b0;
    checks++;
    if (resuming !== 4'b0000) begin failures++; $display("FAIL clear_ack: got %b want 0000", resuming); end
    // hart 3 not halted: resume request ignored
    hartsel = 2'd3;
    pulse_cmd(1'b0, 1'b1);
    bus_rd(12'h400, rd);
    checks++;
    if (rd !== 64'h0) begin failures++; $display("FAIL resume_not_halted: got %h want 0", rd); end
  endtask

  task automatic test_cmd();
    logic [63:0] rd;
    do_reset();
    bus_wr(12'h100, 64'd1, 8'hFF);
    hartsel = 2'd3;
    pulse_cmd(1'b1, 1'b0);
    checks++;
    if (cmdbusy !== 1'b0) begin failures++; $display("FAIL cmd_not_halted: got busy=%b want 0", cmdbusy); end
    hartsel = 2'd1;
    pulse_cmd(1'b1, 1'b1);
    checks++;
    if (cmdbusy !== 1'b1) begin failures++; $display("FAIL cmd_start: got busy=%b want 1", cmdbusy); end
    bus_rd(12'h400, rd);
    checks++;
    if (rd !== 64'h0000_0000_0000_0100) begin failures++; $display("FAIL flags_go: got %h want 100", rd); end
    bus_rd(12'h300, rd);
    checks++;
    if (rd !== {32'h0, JAL_ABS}) begin failures++; $display("FAIL whereto_abs: got %h want %h", rd, {32'h0, JAL_ABS}); end
    bus_wr(12'h108, 64'd0, 8'hFF);
    bus_rd(12'h400, rd);
    checks++;
    if ({cmdbusy, rd} !== {1'b1, 64'h0}) begin failures++; $display("FAIL cmd_exec: got busy=%b flags=%h want 1/0", cmdbusy, rd); end
    pulse_cmd(1'b1, 1'b0);
    bus_rd(12'h400, rd);
    checks++;
    if ({cmdbusy, rd} !== {1'b1, 64'h0}) begin failures++; $display("FAIL cmd_in_exec_ignored: got busy=%b flags=%h want 1/0", cmdbusy, rd); end
    bus_wr(12'h100, 64'd1, 8'hFF);
    checks++;
    if (cmdbusy !== 1'b0) begin failures++; $display("FAIL cmd_done: got busy=%b want 0", cmdbusy); end
    bus_rd(12'h300, rd);
    checks++;
    if (rd !== {32'h0, JAL_PB}) begin failures++; $display("FAIL whereto_pb: got %h want %h", rd, {32'h0, JAL_PB}); end
  endtask

  task automatic test_exception();
    do_reset();
    bus_wr(12'h118, 64'd0, 8'hFF);
    checks++;
    if (cmd_exc !== 1'b0) begin failures++; $display("FAIL exc_idle_ignored: got %b want 0", cmd_exc); end
    bus_wr(12'h100, 64'd1, 8'hFF);
    hartsel = 2'd1;
    pulse_cmd(1'b1, 1'b0);
    bus_wr(12'h108, 64'd0, 8'hFF);
    bus_wr(12'h118, 64'd0, 8'hFF);
    checks++;
    if ({cmd_exc, cmdbusy} !== 2'b10) begin failures++; $display("FAIL exc_pulse: got exc=%b busy=%b want 1/0", cmd_exc, cmdbusy); end
    @(posedge clk); #1;
    checks++;
    if (cmd_exc !== 1'b0) begin failures++; $display("FAIL exc_one_cycle: got %b want 0", cmd_exc); end
  endtask

  task automatic test_resume();
    logic [63:0] rd;
    do_reset();
    bus_wr(12'h100, 64'd1, 8'hFF);
    hartsel = 2'd1;
    pulse_cmd(1'b0, 1'b1);
    bus_rd(12'h400, rd);
    checks++;
    if ({cmdbusy, rd} !== {1'b0, 64'h200}) begin failures++; $display("FAIL flags_resume: got busy=%b flags=%h want 0/200", cmdbusy, rd); end
    bus_wr(12'h110, 64'd1, 8'hFF);
    bus_rd(12'h400, rd);
    checks++;
    if ({halted, resuming, rd} !== {4'b0000, 4'b0010, 64'h0}) begin
      failures++; $display("FAIL resume_done: got h=%b r=%b flags=%h want 0000/0010/0", halted, resuming, rd);
    end
  endtask

  task automatic test_data();
    logic [63:0] rd;
    do_reset();
    bus_wr(12'h380, 64'h11223344_AABBCCDD, 8'h0F);
    checks++;
    if ({data_out[1], data_out[0], data_valid} !== {32'h0, 32'hAABBCCDD, 1'b1}) begin
      failures++; $display("FAIL data_low: got d1=%h d0=%h dv=%b want 0/AABBCCDD/1", data_out[1], data_out[0], data_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL data_valid_once: got %b want 0", data_valid); end
    bus_wr(12'h380, 64'h55667788_000000EE, 8'hF1);
    checks++;
    if ({data_out[1], data_out[0]} !== {32'h55667788, 32'hAABBCCEE}) begin
      failures++; $display("FAIL data_bytes: got d1=%h d0=%h want 55667788/AABBCCEE", data_out[1], data_out[0]);
    end
    data_in = {32'hCAFEBABE, 32'h12345678};
    bus_rd(12'h380, rd);
    checks++;
    if (rd !== 64'hCAFEBABE_12345678) begin failures++; $display("FAIL data_read: got %h want CAFEBABE12345678", rd); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus_wr(12'h100, 64'd0, 8'hFF);
    hartsel = 2'd0;
    @(negedge clk);
    clear_ack = 1'b1;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 12'h110; bus.wdata_i = 64'd0; bus.be_i = 8'hFF;
    @(posedge clk); #1;
    clear_ack = 1'b0; bus.req_i = 1'b0; bus.we_i = 1'b0;
    checks++;
    if ({halted, resuming} !== {4'b0000, 4'b0001}) begin
      failures++; $display("FAIL write_beats_clear: got h=%b r=%b want 0000/0001", halted, resuming);
    end
  endtask

  task automatic test_reads();
    logic [63:0] rd;
    do_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rvalid_o !== 1'b0) begin failures++; $display("FAIL rvalid_idle: got %b want 0", bus.rvalid_o); end
    bus_rd(12'h368, rd);
    checks++;
    if ({bus.rvalid_o, rd} !== {1'b1, 64'hA0000003_A0000002}) begin
      failures++; $display("FAIL progbuf_read: got rv=%b rd=%h want 1/A0000003A0000002", bus.rvalid_o, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rvalid_o !== 1'b0) begin failures++; $display("FAIL rvalid_one_cycle: got %b want 0", bus.rvalid_o); end
    bus_rd(12'h338, rd);
    checks++;
    if (rd !== 64'hB0000001_B0000000) begin failures++; $display("FAIL abscmd_read: got %h want B0000001B0000000", rd); end
    bus_rd(12'h200, rd);
    checks++;
    if (rd !== 64'h0) begin failures++; $display("FAIL unmapped_read: got %h want 0", rd); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd;
    do_reset();
    bus_wr(12'h380, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    bus_wr(12'h100, 64'd2, 8'hFF);
    hartsel = 2'd2;
    pulse_cmd(1'b1, 1'b0);
    checks++;
    if (cmdbusy !== 1'b1) begin failures++; $display("FAIL mid_cmd_start: got %b want 1", cmdbusy); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rvalid_o, bus.rdata_o, halted, resuming, data_out, data_valid, cmdbusy, cmd_exc} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got h=%b d=%h busy=%b, want all 0", halted, data_out, cmdbusy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(12'h400, rd);
    checks++;
    if (rd !== 64'h0) begin failures++; $display("FAIL mid_reset_flags: got %h want 0", rd); end
    bus_rd(12'h300, rd);
    checks++;
    if (rd !== {32'h0, JAL_PB}) begin failures++; $display("FAIL mid_reset_whereto: got %h want %h", rd, {32'h0, JAL_PB}); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++)  progbuf[i] = 32'hA0000000 + 32'(i);
    for (int i = 0; i < 10; i++) abs_cmd[i] = 32'hB0000000 + 32'(i);
    data_in = '0;
    test_reset();
    test_halt_resume();
    test_cmd();
    test_exception();
    test_resume();
    test_data();
    test_same_cycle();
    test_reads();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
